prio_enc_q: RTL and testbench



---
 rtl/prio_enc_pkg.sv | 11 +
 rtl/prio_enc_q_pick.sv | 32 +++
 rtl/prio_enc_q.sv | 79 +++++++
 tb/tb_prio_enc_q.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants and the index-width helper for the registered priority encoder.
package prio_enc_pkg;

  localparam int PRIO_ENC_N_DEFAULT = 8;

  // Width of an index into an n-entry vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_q_pick.sv
// Combinational N-way pick: first set bit scanning downward from start_i, wrapping 0 -> N-1.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int N = PRIO_ENC_N_DEFAULT,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    int j;
    logic [W-1:0] jw;
    j       = 0;
    jw      = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(start_i) - i;
      if (j < 0) j = j + N;
      jw = W'(j);
      if (!found_o && vec_i[jw]) begin
        found_o = 1'b1;
        idx_o   = jw;
      end
    end
  end

endmodule

// File: rtl/prio_enc_q.sv
// Registered N-line priority encoder with valid/ready output and sticky pending bits.
// Define PRIO_ENC_Q_RR_EN for round-robin selection; otherwise highest index wins.
module prio_enc_q
  import prio_enc_pkg::*;
#(
  parameter int N = PRIO_ENC_N_DEFAULT,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_idx_o,
  output logic [N-1:0] pending_o,
  output logic         busy_o
);

  logic [N-1:0] pending_q, pending_d, load_oh;
  logic         out_valid_q;
  logic [W-1:0] out_idx_q, sel, start;
  logic         found, load;

  assign load = !out_valid_q || out_ready_i;

`ifdef PRIO_ENC_Q_RR_EN
  logic [W-1:0] last_q;
  // Search begins one below the last grant; last_q == 0 wraps to N-1 (same as fixed mode).
  assign start = (last_q == '0) ? W'(N - 1) : last_q - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              last_q <= '0;
    else if (flush_i)        last_q <= '0;
    else if (load && found)  last_q <= sel;
  end
`else
  assign start = W'(N - 1);
`endif

  prio_pick #(.N(N)) u_pick (
    .vec_i   (pending_q),
    .start_i (start),
    .idx_o   (sel),
    .found_o (found)
  );

  always_comb begin
    load_oh = '0;
    if (load && found) load_oh[sel] = 1'b1;
  end

  // A request arriving on the bit being granted re-arms it (set wins over clear).
  assign pending_d = (pending_q & ~load_oh) | req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else if (flush_i) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        out_valid_q <= found;
        if (found) out_idx_q <= sel;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;
  assign pending_o   = pending_q;
  assign busy_o      = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_prio_enc_q.sv
// Scoreboard bench for prio_enc_q: stimulus pushes expected grants, a negedge monitor pops them.
module tb_prio_enc_q;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0;
  logic         out_ready_i = 1'b0;
  logic [N-1:0] req_i = '0;
  logic         out_valid_o, busy_o;
  logic [W-1:0] out_idx_o;
  logic [N-1:0] pending_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  prio_enc_q #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_idx_o   (out_idx_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  // Monitor: every accepted grant must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_grant", longint'(out_idx_o), -1);
      else                   chk("grant_idx", longint'(out_idx_o), longint'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / idle
    tick(2);
    rst_n = 1'b1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_idx", out_idx_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_busy", busy_o, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", out_valid_o, 0);
      chk("idle_busy", busy_o, 0);
    end

    // Fixed priority 7,5,2 back to back from cycle 2
    out_ready_i = 1'b1;
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2);
    req_i = 8'hA4;
    tick();
    req_i = '0;
    chk("fx_pend_c1", pending_o, 8'hA4);
    chk("fx_valid_c1", out_valid_o, 0);
    tick(); chk("fx_c2_valid", out_valid_o, 1); chk("fx_c2_idx", out_idx_o, 7);
    tick(); chk("fx_c3_valid", out_valid_o, 1); chk("fx_c3_idx", out_idx_o, 5);
    tick(); chk("fx_c4_valid", out_valid_o, 1); chk("fx_c4_idx", out_idx_o, 2);
    tick(); chk("fx_c5_valid", out_valid_o, 0); chk("fx_c5_busy", busy_o, 0);
    chk("fx_drained", exp_q.size(), 0);

    // Stall hold
    do_flush();
    out_ready_i = 1'b0;
    req_i = 8'h42;
    tick();
    req_i = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid_o, 1);
      chk("stall_idx", out_idx_o, 6);
      chk("stall_pend", pending_o, 8'h02);
      tick();
    end
    exp_q.push_back(6); exp_q.push_back(1);
    out_ready_i = 1'b1;
    tick(3);
    chk("stall_drained", exp_q.size(), 0);
    chk("stall_end_valid", out_valid_o, 0);

    // Set-wins: request re-arrives on the bit being loaded
    do_flush();
    out_ready_i = 1'b1;
    exp_q.push_back(3); exp_q.push_back(3);
    req_i = 8'h08;
    tick();
    tick();
    req_i = '0;
    chk("sw_pend_rearm", pending_o, 8'h08);
    chk("sw_c2_idx", out_idx_o, 3);
    tick();
    chk("sw_c3_valid", out_valid_o, 1);
    chk("sw_c3_idx", out_idx_o, 3);
    tick();
    chk("sw_c4_valid", out_valid_o, 0);
    chk("sw_drained", exp_q.size(), 0);

    // Merge: re-asserting an already pending request gives one grant
    do_flush();
    out_ready_i = 1'b0;
    req_i = 8'h28;
    tick();
    req_i = 8'h08;
    tick(2);
    req_i = '0;
    chk("mg_pend", pending_o, 8'h08);
    chk("mg_hold_idx", out_idx_o, 5);
    exp_q.push_back(5); exp_q.push_back(3);
    out_ready_i = 1'b1;
    tick(4);
    chk("mg_drained", exp_q.size(), 0);
    chk("mg_valid", out_valid_o, 0);
    chk("mg_pend_end", pending_o, 0);

    // All requests held high: fixed gives constant 7, round-robin rotates
    do_flush();
    out_ready_i = 1'b1;
`ifdef PRIO_ENC_Q_RR_EN
    for (int i = 0; i < 8; i++) exp_q.push_back(7 - i);
    exp_q.push_back(7);
`else
    for (int i = 0; i < 9; i++) exp_q.push_back(7);
`endif
    req_i = 8'hFF;
    tick(10);
    req_i = '0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("ff_drained", exp_q.size(), 0);
    chk("ff_flush_valid", out_valid_o, 0);
    chk("ff_flush_pend", pending_o, 0);

    // Flush mid-operation drops pending, output, and the coincident request
    do_flush();
    out_ready_i = 1'b0;
    req_i = 8'h14;
    tick();
    req_i = '0;
    tick();
    chk("fl_pre_valid", out_valid_o, 1);
    chk("fl_pre_idx", out_idx_o, 4);
    chk("fl_pre_pend", pending_o, 8'h04);
    flush_i = 1'b1;
    req_i = 8'h20;
    tick();
    flush_i = 1'b0;
    req_i = '0;
    chk("fl_pend", pending_o, 0);
    chk("fl_valid", out_valid_o, 0);
    chk("fl_busy", busy_o, 0);
    out_ready_i = 1'b1;
    tick(4);
    chk("fl_after_valid", out_valid_o, 0);
    chk("fl_after_pend", pending_o, 0);

    // Asynchronous reset mid-cycle
    out_ready_i = 1'b0;
    req_i = 8'h14;
    tick();
    req_i = '0;
    tick();
    chk("ar_pre_valid", out_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_pend", pending_o, 0);
    chk("ar_idx", out_idx_o, 0);
    chk("ar_busy", busy_o, 0);
    tick();
    rst_n = 1'b1;
    tick(2);
    chk("ar_after_valid", out_valid_o, 0);
    chk("ar_after_busy", busy_o, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
